// File: rtl/sr_mem_arbiter_if.sv
// sr_mem_arbiter_if: request/grant bus between two masters, the arbiter and a single-port memory
//   m0_*/m1_* : req, we, addr, wdata from each master; gnt, rvalid, rdata back to it
//   mem_*     : en, we, addr, wdata to the memory; rdata back one cycle after a read strobe
//   master modport is the requester/memory side, slave modport is the arbiter side
interface sr_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sr_mem_arbiter.sv
// sr_mem_arbiter: two-master single-port memory arbiter with ownership, burst limit and read-return tagging
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; all outputs forced to 0 while low
//   bus   : sr_mem_arbiter_if.slave carrying both master ports and the memory port
module sr_mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int BURST_MAX = 4
) (
  input logic           clk,
  input logic           rst_n,
  sr_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t     state;
  logic [3:0] burst_cnt;
  logic       last_gnt, tag_valid, tag_owner;
  logic       at_max, pick0, gnt0, gnt1, any_gnt, same_owner, sel_we;
  assign at_max = burst_cnt == 4'(BURST_MAX);
  // m0 wins when alone; under contention the tie-break depends on who owns the port:
  // idle -> round-robin, owner 0 -> keep until the burst limit, owner 1 -> take over at the limit
  assign pick0 = bus.m0_req & (~bus.m1_req | (state == IDLE ? last_gnt : state == OWN0 ? ~at_max : at_max));
  assign gnt0 = rst_n & pick0;
  assign gnt1 = rst_n & bus.m1_req & ~pick0;
  assign any_gnt = gnt0 | gnt1;
  assign same_owner = (gnt0 & state == OWN0) | (gnt1 & state == OWN1);
  assign sel_we = gnt0 ? bus.m0_we : gnt1 ? bus.m1_we : 1'b0;
  assign bus.m0_gnt = gnt0;
  assign bus.m1_gnt = gnt1;
  assign bus.mem_en = any_gnt;
  assign bus.mem_we = sel_we;
  assign bus.mem_addr = gnt0 ? bus.m0_addr : gnt1 ? bus.m1_addr : {AW{1'b0}};
  assign bus.mem_wdata = gnt0 ? bus.m0_wdata : gnt1 ? bus.m1_wdata : {DW{1'b0}};
  // rvalid is gated by rst_n so a read in flight when reset asserts is dropped immediately
  assign bus.m0_rvalid = rst_n & tag_valid & ~tag_owner;
  assign bus.m1_rvalid = rst_n & tag_valid & tag_owner;
  assign bus.m0_rdata = bus.m0_rvalid ? bus.mem_rdata : {DW{1'b0}};
  assign bus.m1_rdata = bus.m1_rvalid ? bus.mem_rdata : {DW{1'b0}};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      burst_cnt <= 4'd0;
      last_gnt  <= 1'b1;
      tag_valid <= 1'b0;
      tag_owner <= 1'b0;
    end else begin
      state     <= gnt0 ? OWN0 : gnt1 ? OWN1 : IDLE;
      burst_cnt <= !any_gnt ? 4'd0 : !same_owner ? 4'd1 : at_max ? burst_cnt : burst_cnt + 4'd1;
      last_gnt  <= any_gnt ? gnt1 : last_gnt;
      tag_valid <= any_gnt & ~sel_we;
      tag_owner <= gnt1;
    end
endmodule

// File: tb/tb_sr_mem_arbiter.sv
// tb_sr_mem_arbiter: directed stimulus with a behavioural arbitration model checked every cycle
module tb_sr_mem_arbiter;
  localparam int BM = 4;
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} op_t;
  logic clk = 0, rst_n = 0;
  int errors = 0, checks = 0, cyc = 0;
  op_t q0[$], q1[$];
  logic fire0 = 0, fire1 = 0;
  int own = -1, cnt = 0, last = 1, pend_own = 0;
  logic pend = 0;
  logic [31:0] pend_addr = 0;
  logic [7:0] g0v, g1v, r0v, r1v;

  sr_mem_arbiter_if #(.AW(32), .DW(32)) bus();
  sr_mem_arbiter #(.AW(32), .DW(32), .BURST_MAX(BM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", n, a, e, $time);
    end
  endtask

  function automatic logic [31:0] rd_val(logic [31:0] a);
    return a == 32'h10 ? 32'hDEADBEEF : (a * 32'h01010101) ^ 32'h5A5A0000;
  endfunction

  // who must own the memory this cycle, from the arbitration rules
  function automatic int winner();
    if (!rst_n) return -1;
    if (bus.m0_req && bus.m1_req) return own < 0 ? 1 - last : (cnt == BM ? 1 - own : own);
    return bus.m0_req ? 0 : bus.m1_req ? 1 : -1;
  endfunction

  // memory: returns rd_val of the strobed address, junk otherwise
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.mem_rdata <= (bus.mem_en && !bus.mem_we) ? rd_val(bus.mem_addr) : {16'hBAD0, cyc[15:0]};
  end

  // requesters: present head of queue, retire it on the edge where it was granted
  always @(posedge clk) begin
    op_t o0, o1;
    if (rst_n && fire0 && q0.size() != 0) void'(q0.pop_front());
    if (rst_n && fire1 && q1.size() != 0) void'(q1.pop_front());
    #1;
    o0 = q0.size() != 0 ? q0[0] : '0;
    o1 = q1.size() != 0 ? q1[0] : '0;
    bus.m0_req = q0.size() != 0; bus.m0_we = o0.we; bus.m0_addr = o0.addr; bus.m0_wdata = o0.wdata;
    bus.m1_req = q1.size() != 0; bus.m1_we = o1.we; bus.m1_addr = o1.addr; bus.m1_wdata = o1.wdata;
  end

  // model state advance
  always @(posedge clk)
    if (!rst_n) begin
      own <= -1; cnt <= 0; last <= 1; pend <= 0;
    end else begin
      pend      <= winner() >= 0 && !(winner() == 0 ? bus.m0_we : bus.m1_we);
      pend_own  <= winner();
      pend_addr <= winner() == 0 ? bus.m0_addr : bus.m1_addr;
      if (winner() >= 0) begin
        cnt  <= winner() == own ? (cnt < BM ? cnt + 1 : BM) : 1;
        own  <= winner();
        last <= winner();
      end else own <= -1;
    end

  // per-cycle compare
  always @(negedge clk) begin
    int w;
    logic we, rv0, rv1;
    logic [31:0] a, d;
    w   = winner();
    we  = w == 0 ? bus.m0_we : bus.m1_we;
    a   = w == 0 ? bus.m0_addr : w == 1 ? bus.m1_addr : 32'h0;
    d   = w == 0 ? bus.m0_wdata : w == 1 ? bus.m1_wdata : 32'h0;
    rv0 = rst_n && pend && pend_own == 0;
    rv1 = rst_n && pend && pend_own == 1;
    chk("m0_gnt", bus.m0_gnt, w == 0);
    chk("m1_gnt", bus.m1_gnt, w == 1);
    chk("mem_en", bus.mem_en, w >= 0);
    chk("mem_we", bus.mem_we, w >= 0 && we);
    chk("mem_addr", bus.mem_addr, a);
    chk("mem_wdata", bus.mem_wdata, d);
    chk("m0_rvalid", bus.m0_rvalid, rv0);
    chk("m1_rvalid", bus.m1_rvalid, rv1);
    chk("m0_rdata", bus.m0_rdata, rv0 ? rd_val(pend_addr) : 32'h0);
    chk("m1_rdata", bus.m1_rdata, rv1 ? rd_val(pend_addr) : 32'h0);
    fire0 <= bus.m0_req && bus.m0_gnt;
    fire1 <= bus.m1_req && bus.m1_gnt;
  end

  task automatic drain();
    for (int k = 0; k < 100 && (q0.size() != 0 || q1.size() != 0); k++) @(negedge clk);
    chk("drain_timeout", q0.size() + q1.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_m0_gnt", bus.m0_gnt, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_m0_rvalid", bus.m0_rvalid, 0);
    rst_n = 1;
    // single read returning DEADBEEF
    q0.push_back('{1'b0, 32'h10, 32'h0});
    @(negedge clk); chk("rd_m0_gnt", bus.m0_gnt, 1);
    @(negedge clk); chk("rd_m0_rvalid", bus.m0_rvalid, 1);
    chk("rd_m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
    chk("rd_m1_rvalid", bus.m1_rvalid, 0);
    @(negedge clk); chk("rd_m0_rvalid_once", bus.m0_rvalid, 0);
    // simultaneous first requests after reset
    rst_n = 0; repeat (2) @(negedge clk); rst_n = 1;
    q0.push_back('{1'b0, 32'h40, 32'h0});
    q1.push_back('{1'b0, 32'h44, 32'h0});
    g0v = 0; g1v = 0; r0v = 0; r1v = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      g0v[k] = bus.m0_gnt; g1v[k] = bus.m1_gnt; r0v[k] = bus.m0_rvalid; r1v[k] = bus.m1_rvalid;
      if (k == 2) chk("tie_m1_rdata", bus.m1_rdata, 32'h1E1E4444);
    end
    chk("tie_m0_gnt_seq", g0v, 8'b0000_0001);
    chk("tie_m1_gnt_seq", g1v, 8'b0000_0010);
    chk("tie_m0_rv_seq", r0v, 8'b0000_0010);
    chk("tie_m1_rv_seq", r1v, 8'b0000_0100);
    drain();
    // burst limit
    for (int k = 0; k < 6; k++) q0.push_back('{1'b0, 32'h100 + k, 32'h0});
    q1.push_back('{1'b0, 32'h200, 32'h0});
    g0v = 0; g1v = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      g0v[k] = bus.m0_gnt; g1v[k] = bus.m1_gnt;
    end
    chk("burst_m0_gnt_seq", g0v, 8'b0110_1111);
    chk("burst_m1_gnt_seq", g1v, 8'b0001_0000);
    drain();
    // write passthrough
    q1.push_back('{1'b1, 32'h20, 32'h12345678});
    @(negedge clk);
    chk("wr_m1_gnt", bus.m1_gnt, 1);
    chk("wr_mem_en", bus.mem_en, 1);
    chk("wr_mem_we", bus.mem_we, 1);
    chk("wr_mem_addr", bus.mem_addr, 32'h20);
    chk("wr_mem_wdata", bus.mem_wdata, 32'h12345678);
    @(negedge clk); chk("wr_mem_en_after", bus.mem_en, 0); chk("wr_no_rvalid", bus.m1_rvalid, 0);
    @(negedge clk); chk("wr_no_rvalid2", bus.m1_rvalid, 0);
    // idle stretch then a lone m1 request
    repeat (10) begin
      @(negedge clk);
      chk("idle_mem_en", bus.mem_en, 0);
      chk("idle_mem_addr", bus.mem_addr, 0);
    end
    q1.push_back('{1'b0, 32'h30, 32'h0});
    @(negedge clk); chk("idle_m1_gnt", bus.m1_gnt, 1);
    drain();
    // burst counter saturates: m1 arriving late takes over at once
    for (int k = 0; k < 8; k++) q0.push_back('{1'b0, 32'h80 + k, 32'h0});
    repeat (6) @(negedge clk);
    q1.push_back('{1'b0, 32'h90, 32'h0});
    @(negedge clk); chk("sat_m1_gnt", bus.m1_gnt, 1);
    drain();
    // mixed traffic, alternating owners and interleaved writes
    for (int k = 0; k < 7; k++) begin
      q0.push_back('{k == 1, 32'h50 + k, 32'hA000 + k});
      q1.push_back('{k == 2, 32'h60 + k, 32'hB000 + k});
    end
    drain();
    // reset mid-read drops the return
    q0.push_back('{1'b0, 32'h70, 32'h0});
    @(negedge clk); chk("rstmid_m0_gnt", bus.m0_gnt, 1);
    #2 rst_n = 0;
    q0.delete();
    #1 chk("rstmid_gnt_gated", bus.m0_gnt, 0);
    chk("rstmid_mem_en", bus.mem_en, 0);
    @(negedge clk);
    chk("rstmid_m0_rvalid", bus.m0_rvalid, 0);
    chk("rstmid_m0_rdata", bus.m0_rdata, 0);
    chk("rstmid_mem_addr", bus.mem_addr, 0);
    rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_no_late_rvalid", bus.m0_rvalid, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sr_mem_arbiter.md
SR_MEM_ARBITER -- requirements
Module: sr_mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning the word address width.
REQ-002 The block SHALL have parameter DW, default 32, meaning the data width.
REQ-003 The block SHALL have parameter BURST_MAX, default 4 (legal 1..15), meaning the maximum number of consecutive grants to one owner while the other requester waits.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
  clk  in  1  clock, all state updates on its rising edge
  rst_n  in  1  asynchronous active-low reset
  m0_req  in  1  master 0 (CPU data port) access request, held until granted
  m0_we  in  1  master 0 write (1) / read (0)
  m0_addr  in  AW  master 0 word address
  m0_wdata  in  DW  master 0 write data
  m0_gnt  out  1  master 0 access accepted this cycle
  m0_rvalid  out  1  master 0 read data valid
  m0_rdata  out  DW  master 0 read data
  m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as the m0 ports, for master 1 (debug/loader port)
  mem_en  out  1  memory access strobe
  mem_we  out  1  memory write enable
  mem_addr  out  AW  memory address
  mem_wdata  out  DW  memory write data
  mem_rdata  in  DW  memory read data, valid one cycle after a read strobe

Function
REQ-005 States SHALL be IDLE, OWN0 and OWN1. OWNx means master x holds ownership.
REQ-006 Grants SHALL be combinational from the current state and mX_req. At most one mX_gnt SHALL be high in any cycle.
REQ-007 An access SHALL complete on the rising edge at which mX_req and mX_gnt are both high. Requesters SHALL hold req, we, addr and wdata stable until granted.
REQ-008 The mem_* outputs SHALL mirror the granted master's we/addr/wdata, and mem_en SHALL equal m0_gnt | m1_gnt.
REQ-009 When mem_en is 0, mem_we SHALL be 0. mem_addr and mem_wdata SHALL then be 0.
REQ-010 IDLE, single requester: that requester SHALL be granted, and the state SHALL go to its OWNx.
REQ-011 IDLE, both requesting: the master not granted most recently (last_gnt pointer) SHALL be granted.
REQ-012 OWNx, mx_req high, and either the other master is not requesting or burst_cnt < BURST_MAX: master x SHALL be granted.
REQ-013 OWNx, other master requesting and burst_cnt == BURST_MAX: the other master SHALL be granted in that same cycle, with no idle cycle, and the state SHALL move to its OWN.
REQ-014 OWNx, mx_req low, other master requesting: the other master SHALL be granted in the same cycle.
REQ-015 OWNx, no requests: nothing SHALL be granted, and the state SHALL return to IDLE.
REQ-016 burst_cnt (4 bits) SHALL be set to 1 on a grant that changes owner or leaves IDLE, and SHALL be incremented on each same-owner grant.
REQ-017 burst_cnt SHALL saturate at BURST_MAX and SHALL NOT wrap.
REQ-018 last_gnt SHALL update to the index of every granted master.
REQ-019 For read grants, a registered tag (valid, owner) SHALL raise mX_rvalid for exactly one cycle, on the cycle after the grant, for that owner only.
REQ-020 mX_rdata SHALL equal mem_rdata while mX_rvalid is high and SHALL be 0 otherwise.
REQ-021 Write grants SHALL produce no rvalid.
REQ-022 Back-to-back reads, including reads alternating between owners, SHALL each return rvalid in consecutive cycles with no bubble.
REQ-023 A grant of one master and an rvalid for the other master in the same cycle SHALL be legal and independent.

Reset
REQ-024 While rst_n is low, the state SHALL be IDLE, burst_cnt 0, last_gnt 1 (master 0 wins the first tie), and the rvalid tag cleared.
REQ-025 While rst_n is low, all outputs (mX_gnt, mX_rvalid, mX_rdata, mem_en, mem_we, mem_addr, mem_wdata) SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL drop any pending rvalid. No rvalid SHALL appear after rst_n deasserts for accesses granted before reset.
REQ-027 Deassertion of rst_n SHALL take effect at the next rising edge of clk. No grant SHALL occur in a cycle in which rst_n is low.

Verification
REQ-028 Reset then single read: m0 reads addr 0x10, and mem returns 0xDEADBEEF -> m0_gnt in cycle 0, m0_rvalid with m0_rdata=0xDEADBEEF in cycle 1, m1_rvalid stays 0.
REQ-029 Simultaneous first requests after reset: m0 and m1 both read -> m0 granted first, m1 granted the next cycle, rvalids in cycles 1 and 2 respectively.
REQ-030 Burst limit with BURST_MAX=4: m0 requests continuously and m1 requests from cycle 0 -> m0 granted in cycles 0-3, m1 in cycle 4, m0 again in cycle 5 once m1 drops req.
REQ-031 Write passthrough: m1 writes 0x1234_5678 to addr 0x20 -> mem_en=1, mem_we=1, mem_addr=0x20, mem_wdata=0x12345678 for one cycle, no m1_rvalid.
REQ-032 Reset mid-read: m0 read granted, rst_n pulled low before the next edge -> m0_rvalid never asserts, and all outputs are 0 while in reset.
REQ-033 Idle behaviour: no requests for 10 cycles -> mem_en=0, mem_addr=0, state IDLE throughout, and a later lone m1 request is granted immediately.
